// File: rtl/psum_collector.sv
// psum_collector: accumulates kernel_size psums per pixel, saturates, and queues pixels with row-last tags
module psum_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int PW = 2 * DATA_WIDTH,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [7:0]           kernel_size,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [PW-1:0] in_psum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        out_data,
  output logic                 out_last,
  output logic [CW-1:0]        fifo_count,
  output logic                 ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CLW = NUM_COL > 1 ? $clog2(NUM_COL) : 1;
  localparam logic [PW-1:0] SMAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] SMIN = {1'b1, {(PW-1){1'b0}}};
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nx;
  logic [7:0] k, beat;
  logic [CLW-1:0] col;
  logic [PW-1:0] acc, sum;
  logic [PW:0] wide;
  logic [PW:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic full, done, xfer, clamp, push, pop, col_end;
  always_comb begin
    full = count == CW'(FIFO_DEPTH);
    done = beat == k - 8'd1;
    in_ready = state == ACCUM && !(done && full);
    xfer = in_valid && in_ready && !flush;
    wide = {acc[PW-1], acc} + {in_psum[PW-1], in_psum};
    clamp = beat != 8'd0 && wide[PW] != wide[PW-1];
    sum = beat == 8'd0 ? in_psum : clamp ? (wide[PW] ? SMIN : SMAX) : wide[PW-1:0];
    push = xfer && done;
    pop = out_valid && out_ready;
    col_end = col == CLW'(NUM_COL - 1);
    state_nx = flush ? IDLE : state == IDLE ? (en ? ACCUM : IDLE) : (push && !en) ? IDLE : ACCUM;
    out_valid = count != '0;
    out_data = out_valid ? mem[rd_ptr][PW-1:0] : '0;
    out_last = out_valid && mem[rd_ptr][PW];
    fifo_count = count;
  end
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state <= IDLE;
      k <= 8'd1;
      beat <= '0;
      acc <= '0;
      col <= '0;
      ovf <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && en && !flush) k <= kernel_size == 8'd0 ? 8'd1 : kernel_size;
      if (flush) begin
        beat <= '0;
        acc <= '0;
        col <= '0;
      end else if (xfer) begin
        acc <= sum;
        beat <= done ? 8'd0 : beat + 8'd1;
        if (done) col <= col_end ? '0 : col + CLW'(1);
      end
      if (xfer && clamp) ovf <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Storage is left unreset; reads are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {col_end, sum};
  end
endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: table-driven vectors plus scoreboard checks for psum_collector
module tb_psum_collector;
  logic clk = 0, rstn = 1, en = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [7:0] kernel_size = 8'd1;
  logic [31:0] in_psum = '0;
  logic in_ready, out_valid, out_last, ovf;
  logic [31:0] out_data;
  logic [3:0] fifo_count;
  int checks = 0, errors = 0;
  logic [32:0] q[$];
  logic [32:0] e_m;
  typedef struct {
    logic nw;
    logic [7:0] k;
    logic [31:0] p0, p1, p2, exp;
    logic last, ov;
  } row_t;
  row_t rows[12];

  always #5 clk = ~clk;

  psum_collector dut (
    .clk(clk), .rstn(rstn), .en(en), .kernel_size(kernel_size), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .fifo_count(fifo_count), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got %0h expected no output", out_data);
      end else begin
        e_m = q.pop_front();
        chk("sb_data", out_data, e_m[31:0]);
        chk("sb_last", out_last, e_m[32]);
      end
    end
  end

  task automatic start(input logic [7:0] kk);
    kernel_size = kk;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    en = 1;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] p);
    int n;
    n = 0;
    in_valid = 1;
    in_psum = p;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for psum %0h", p);
      in_valid = 0;
    end else begin
      @(posedge clk); #1;
      in_valid = 0;
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int n;
    rows[0]  = '{1, 3, 1, 2, 3, 6, 0, 0};
    rows[1]  = '{0, 3, 10, 20, 30, 60, 0, 0};
    rows[2]  = '{1, 1, 5, 0, 0, 5, 0, 0};
    rows[3]  = '{0, 1, 6, 0, 0, 6, 0, 0};
    rows[4]  = '{0, 1, 7, 0, 0, 7, 0, 0};
    rows[5]  = '{0, 1, 8, 0, 0, 8, 1, 0};
    rows[6]  = '{0, 1, 9, 0, 0, 9, 0, 0};
    rows[7]  = '{1, 0, 42, 0, 0, 42, 0, 0};
    rows[8]  = '{1, 3, 32'h7FFFFFF0, 32'h20, 0, 32'h7FFFFFFF, 0, 1};
    rows[9]  = '{0, 3, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFF1, 0, 1};
    rows[10] = '{0, 3, 32'h80000000, 32'hFFFFFFFF, 5, 32'h80000005, 0, 1};
    rows[11] = '{0, 3, 1, 1, 1, 3, 1, 1};
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", ovf, 0);
    rstn = 0;
    @(posedge clk); #1;
    for (int r = 0; r < 12; r++) begin
      n = rows[r].k == 0 ? 1 : int'(rows[r].k);
      if (rows[r].nw) start(rows[r].k);
      for (int b = 0; b < n; b++) begin
        if (b == n - 1) q.push_back({rows[r].last, rows[r].exp});
        send(b == 0 ? rows[r].p0 : b == 1 ? rows[r].p1 : rows[r].p2);
        if (b < n - 1 && q.size() == 0) chk("early_valid", out_valid, 0);
      end
      chk("latency", out_valid, 1);
      chk("ovf", ovf, rows[r].ov);
    end
    drain();
    // backpressure: fill the FIFO, then release the output side
    start(1);
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      q.push_back({i % 4 == 3, 32'(100 + i)});
      send(32'(100 + i));
    end
    chk("bp_full", fifo_count, 8);
    in_valid = 1;
    in_psum = 32'd108;
    q.push_back({1'b0, 32'd108});
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_ready", in_ready, 0);
      chk("bp_hold", out_data, 100);
      chk("bp_hold_last", out_last, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_reopen", in_ready, 1);
    chk("bp_count7", fifo_count, 7);
    @(posedge clk); #1;
    in_valid = 0;
    chk("bp_pushpop", fifo_count, 7);
    drain();
    // flush: queued pixel survives, partial group and same-cycle psum discarded
    start(1);
    out_ready = 0;
    q.push_back({1'b0, 32'd77});
    send(77);
    start(3);
    send(4);
    send(4);
    flush = 1;
    in_valid = 1;
    in_psum = 32'd100;
    @(posedge clk); #1;
    flush = 0;
    in_valid = 0;
    chk("fl_count", fifo_count, 1);
    chk("fl_ovf_kept", ovf, 1);
    out_ready = 1;
    for (int g = 0; g < 4; g++) begin
      q.push_back({g == 3, 32'(3 * g + 6)});
      send(32'(g + 1));
      send(32'(g + 2));
      send(32'(g + 3));
    end
    drain();
    // asynchronous reset between edges with a partially filled FIFO
    out_ready = 0;
    start(1);
    send(11);
    send(12);
    send(13);
    start(2);
    send(21);
    chk("pre_rst_count", fifo_count, 3);
    @(posedge clk); #3;
    rstn = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_data", out_data, 0);
    chk("arst_ovf", ovf, 0);
    #2;
    rstn = 0;
    out_ready = 1;
    kernel_size = 2;
    en = 1;
    @(posedge clk); #1;
    q.push_back({1'b0, 32'd2});
    send(1);
    send(1);
    chk("post_rst_latency", out_valid, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Downstream stage of a PE column chain. Consumes partial sums leaving the last PE's output interface (psum_data_P2P with VALID/READY).
- Accumulates kernel_size consecutive psums, one per PE row, into one output pixel.
- Buffers finished pixels in a FIFO and streams them to the global buffer write-back port, tagging the last pixel of each output row.

Parameters:
- DATA_WIDTH, 16: ifmap/filter width. Psum width PW = 2*DATA_WIDTH.
- NUM_COL, 4: output pixels per output row. out_last is asserted every NUM_COL outputs.
- FIFO_DEPTH, 8: output FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  asynchronous, active-high reset. The block is in reset while rstn=1.
- en  input  1  enable; sampled only in IDLE.
- kernel_size  input  8  rows to accumulate per output; latched on IDLE->ACCUM.
- flush  input  1  single-cycle pulse; abandons the partial accumulation.
- in_valid  input  1  upstream psum valid (from the PE's VALID).
- in_ready  output  1  collector can accept a psum.
- in_psum  input  PW  signed partial sum.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  write-back accepts the head.
- out_data  output  PW  accumulated, saturated pixel.
- out_last  output  1  head is the last pixel of a row.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovf  output  1  sticky saturation flag.

Behaviour:
- Reset (async, rstn=1): immediately forces in_ready=0, out_valid=0, out_data=0, out_last=0, fifo_count=0, ovf=0. Also clears state to IDLE and clears the accumulator, beat counter and column counter. All FIFO contents are lost.
- States:
  - IDLE: in_ready=0. If en=1, latch k=max(kernel_size,1) and go to ACCUM.
  - ACCUM: accepts psums.
- Transfer rule: a psum transfers when in_valid & in_ready at the clock edge.
- in_ready = (state==ACCUM) && !(beat==k-1 && fifo full). in_ready never depends on in_valid.
- Per transfer: acc <= (beat==0 ? in_psum : sat(acc+in_psum)), and beat increments.
- Completing beat (beat==k-1):
  - Push sat(acc+in_psum) into the FIFO (or in_psum alone when k=1), with last flag = (col==NUM_COL-1).
  - Reset beat to 0. Set col <= (col==NUM_COL-1) ? 0 : col+1.
  - Go to IDLE if en=0 on that cycle; otherwise stay in ACCUM.
  - Latency: the pixel appears at out_valid the cycle after its last input beat.
- en deasserted mid-group does not abort; the current group completes first.
- Saturation:
  - The sum is computed in PW+1 bits and clamped to [-2^(PW-1), 2^(PW-1)-1].
  - Any clamp sets ovf. ovf stays 1 until reset.
  - Intermediate beats also saturate.
- flush=1:
  - Clears beat, acc and col. Goes to IDLE, which re-latches kernel_size.
  - A transfer in the same cycle is discarded.
  - FIFO contents and ovf are kept; the output side keeps draining.
- FIFO:
  - Pop on out_valid & out_ready.
  - out_data/out_last show the head, registered. They are stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle are allowed when not full; fifo_count is unchanged.
  - No push when full, even if a pop occurs that cycle (no bypass).
  - Pointers wrap modulo FIFO_DEPTH. fifo_count is exact, range 0..FIFO_DEPTH.
- kernel_size changes while in ACCUM are ignored.

Test Plan:
1. Basic: k=3, en=1, out_ready=1, psums 1,2,3,10,20,30 -> outputs 6 then 60. Each appears 1 cycle after its 3rd beat. out_last=0 on both.
2. Row tag: k=1, NUM_COL=4, psums 5,6,7,8,9 -> out_data 5,6,7,8,9 with out_last=0,0,0,1,0.
3. Backpressure: k=1, out_ready=0, 9 psums offered -> 8 accepted, fifo_count=8, in_ready=0 on the 9th. Raise out_ready -> 9th accepted one cycle after the first pop. Output order is preserved.
4. Saturation: k=3, psums 0x7FFFFFF0, 0x00000020, 0x00000000 -> out_data=0x7FFFFFFF, ovf=1. Next group -5,-5,-5 -> -15, and ovf stays 1.
5. Flush: k=3, psums 4,4 then flush pulse, then 1,2,3 -> single output 6. A pixel queued earlier is still delivered. col restarts, so out_last appears on the 4th subsequent output.
6. Reset mid-operation: FIFO holds 3 entries and beat=1, then rstn=1 asynchronously between clock edges -> out_valid=0 and fifo_count=0 before the next edge. After release, k=2, psums 1,1 -> output 2.
